// File: rtl/data_mem_if.sv
// CPU data-memory port plus the TX byte stream, bundled as one interface.
// The master is the CPU/downstream side and the slave is the responder.
interface data_mem_if;
    logic [3:0]  mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output mem_write_en, mem_read_en, mem_addr, mem_write_data, tx_ready,
        input  mem_read_data, tx_valid, tx_data
    );

    modport slave (
        input  mem_write_en, mem_read_en, mem_addr, mem_write_data, tx_ready,
        output mem_read_data, tx_valid, tx_data
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM, plus an MMIO window holding a cycle counter,
// a byte TX FIFO and its status. Read data is registered, with one-cycle latency.
module data_mem_responder #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    data_mem_if.slave  bus
);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = FIFO_AW + 1;

    localparam logic [15:0] OFF_CNT    = 16'h0000;
    localparam logic [15:0] OFF_TXDATA = 16'h0004;
    localparam logic [15:0] OFF_STATUS = 16'h0008;

    logic [31:0] ram [0:(2**ADDR_W)-1];
    logic [7:0]  fifo_mem [0:FIFO_DEPTH-1];

    logic [31:0]        cycle_cnt;
    logic [31:0]        read_data_q;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;

    // Address decode
    logic              is_mmio;
    logic [15:0]       offset;
    logic [ADDR_W-1:0] ram_idx;
    logic              sel_cnt, sel_tx, sel_status;

    assign is_mmio    = (bus.mem_addr[31:16] == 16'hFFFF);
    assign offset     = bus.mem_addr[15:0];
    assign ram_idx    = bus.mem_addr[ADDR_W+1:2];
    assign sel_cnt    = is_mmio && (offset == OFF_CNT);
    assign sel_tx     = is_mmio && (offset == OFF_TXDATA);
    assign sel_status = is_mmio && (offset == OFF_STATUS);

    // FIFO control
    logic fifo_full, pop, push_req, push_ok, overflow_set, overflow_clr;

    assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop          = bus.tx_valid && bus.tx_ready;
    assign push_req     = en && sel_tx && bus.mem_write_en[0];
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok      = push_req && (!fifo_full || pop);
    assign overflow_set = push_req && fifo_full && !pop;
    assign overflow_clr = en && sel_status && (|bus.mem_write_en);

    // Read mux; values are taken before this edge's updates.
    logic [31:0] read_word;

    always_comb begin
        // NOTE: default assignment first so no path through the block infers a latch.
        read_word = 32'h0;
        if (is_mmio) begin
            if (sel_cnt)
                read_word = cycle_cnt;
            else if (sel_status)
                read_word = {overflow, 15'b0, 16'(count)};
        end else begin
            read_word = ram[ram_idx];
        end
    end

    // NOTE: the RAM and FIFO storage have no reset; only control state is reset, so they can map onto plain memories.
    always_ff @(posedge clk) begin
        if (en && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_write_en[i])
                    ram[ram_idx][8*i +: 8] <= bus.mem_write_data[8*i +: 8];
            end
        end
        if (push_ok)
            fifo_mem[wr_ptr] <= bus.mem_write_data[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values (this gives read-before-write).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= 32'h0;
            cycle_cnt   <= 32'h0;
        end else if (en) begin
            if (bus.mem_read_en)
                read_data_q <= read_word;
            if (sel_cnt && (bus.mem_write_en == 4'hF))
                cycle_cnt <= bus.mem_write_data;
            else
                cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // An overflowing push beats a same-edge clear.
            overflow <= overflow_set || (overflow && !overflow_clr);
        end
    end

    assign bus.mem_read_data = read_data_q;
    assign bus.tx_valid      = (count != '0);
    assign bus.tx_data       = bus.tx_valid ? fifo_mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder, with a queue/array reference model
// checked on every falling edge, plus hand-computed literal checkpoints.
module tb_data_mem_responder;
    localparam int ADDR_W     = 10;
    localparam int FIFO_DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    data_mem_if bus ();

    data_mem_responder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model
    logic [31:0] m_ram [0:(2**ADDR_W)-1];
    logic [7:0]  m_q [$];
    logic [31:0] m_cnt;
    logic [31:0] m_rd;
    logic        m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_cnt = 0;
            m_rd  = 0;
            m_ovf = 0;
        end else begin
            automatic logic        mmio  = (bus.mem_addr[31:16] == 16'hFFFF);
            automatic logic [15:0] off   = bus.mem_addr[15:0];
            automatic int          idx   = int'(bus.mem_addr[ADDR_W+1:2]);
            automatic logic        do_pop = (m_q.size() != 0) && bus.tx_ready;
            automatic logic        ovf_set = 0;
            automatic logic        ovf_clr = 0;
            automatic logic        do_push = 0;
            if (en) begin
                if (bus.mem_read_en) begin
                    if (!mmio)               m_rd = m_ram[idx];
                    else if (off == 16'h0)   m_rd = m_cnt;
                    else if (off == 16'h8)   m_rd = {m_ovf, 15'b0, 16'(m_q.size())};
                    else                     m_rd = 0;
                end
                if (!mmio)
                    for (int i = 0; i < 4; i++)
                        if (bus.mem_write_en[i]) m_ram[idx][8*i +: 8] = bus.mem_write_data[8*i +: 8];
                if (mmio && off == 16'h0 && bus.mem_write_en == 4'hF) m_cnt = bus.mem_write_data;
                else                                                  m_cnt = m_cnt + 1;
                if (mmio && off == 16'h4 && bus.mem_write_en[0]) begin
                    if (m_q.size() < FIFO_DEPTH || do_pop) do_push = 1;
                    else                                   ovf_set = 1;
                end
                ovf_clr = mmio && off == 16'h8 && (|bus.mem_write_en);
            end
            if (do_pop)  void'(m_q.pop_front());
            if (do_push) m_q.push_back(bus.mem_write_data[7:0]);
            m_ovf = ovf_set | (m_ovf & ~ovf_clr);
        end
    end

    always @(negedge clk) begin
        check("model_read_data", bus.mem_read_data, m_rd);
        check("model_tx_valid", 32'(bus.tx_valid), 32'(m_q.size() != 0));
        check("model_tx_data", 32'(bus.tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    end

    // One bus cycle: drive just after an edge, then let the next edge take it.
    task automatic cyc(input logic e, input logic [3:0] we, input logic re,
                       input logic [31:0] a, input logic [31:0] d);
        en                 = e;
        bus.mem_write_en   = we;
        bus.mem_read_en    = re;
        bus.mem_addr       = a;
        bus.mem_write_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b1, 4'h0, 1'b0, 32'h0, 32'h0);
    endtask

    localparam logic [31:0] CNT_A  = 32'hFFFF_0000;
    localparam logic [31:0] TX_A   = 32'hFFFF_0004;
    localparam logic [31:0] STAT_A = 32'hFFFF_0008;

    logic [7:0] drain_exp [8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};

    initial begin
        bus.mem_write_en   = 4'h0;
        bus.mem_read_en    = 1'b0;
        bus.mem_addr       = 32'h0;
        bus.mem_write_data = 32'h0;
        bus.tx_ready       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_read_data", bus.mem_read_data, 32'h0);
        check("reset_tx_valid", 32'(bus.tx_valid), 32'h0);
        check("reset_tx_data", 32'(bus.tx_data), 32'h0);
        rst = 1'b0;

        // RAM word then byte-lane write
        cyc(1, 4'hF, 0, 32'h100, 32'hDEADBEEF);
        cyc(1, 4'b0010, 0, 32'h100, 32'h0000_5500);
        cyc(1, 4'h0, 1, 32'h100, 32'h0);
        check("ram_lane_merge", bus.mem_read_data, 32'hDEAD55EF);

        // en gating
        cyc(1, 4'hF, 0, CNT_A, 32'h0000_1000);
        cyc(1, 4'h0, 1, 32'h100, 32'h0);
        cyc(0, 4'hF, 1, 32'h100, 32'h1234_5678);
        cyc(0, 4'h0, 1, 32'h104, 32'h0);
        cyc(0, 4'hF, 1, 32'h100, 32'h8765_4321);
        check("en_low_hold", bus.mem_read_data, 32'hDEAD55EF);
        cyc(1, 4'h0, 1, CNT_A, 32'h0);
        check("en_low_cnt_frozen", bus.mem_read_data, 32'h0000_1001);
        cyc(1, 4'h0, 1, 32'h100, 32'h0);
        check("en_low_ram_kept", bus.mem_read_data, 32'hDEAD55EF);

        // CNT load and wrap
        cyc(1, 4'hF, 0, CNT_A, 32'hFFFF_FFFE);
        idle();
        cyc(1, 4'h0, 1, CNT_A, 32'h0);
        check("cnt_before_wrap", bus.mem_read_data, 32'hFFFF_FFFF);
        cyc(1, 4'h0, 1, CNT_A, 32'h0);
        check("cnt_wrap", bus.mem_read_data, 32'h0);
        cyc(1, 4'b0001, 0, CNT_A, 32'h0000_0077);
        cyc(1, 4'h0, 1, CNT_A, 32'h0);
        check("cnt_partial_ignored", bus.mem_read_data, 32'h2);

        // FIFO fill and overflow
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) cyc(1, 4'b0001, 0, TX_A, 32'(i));
        cyc(1, 4'h0, 1, STAT_A, 32'h0);
        check("status_overflow", bus.mem_read_data, 32'h8000_0008);
        check("fifo_head", 32'(bus.tx_data), 32'h1);
        cyc(1, 4'b0100, 0, STAT_A, 32'h0);
        cyc(1, 4'h0, 1, STAT_A, 32'h0);
        check("status_cleared", bus.mem_read_data, 32'h0000_0008);

        // Full FIFO: push and pop on the same edge
        bus.tx_ready = 1'b1;
        cyc(1, 4'b0001, 0, TX_A, 32'h0000_00AA);
        bus.tx_ready = 1'b0;
        cyc(1, 4'h0, 1, STAT_A, 32'h0);
        check("full_push_pop_status", bus.mem_read_data, 32'h0000_0008);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", 32'(bus.tx_valid), 32'h1);
            check("drain_byte", 32'(bus.tx_data), 32'(drain_exp[i]));
            idle();
        end
        check("drained_empty", 32'(bus.tx_valid), 32'h0);
        check("drained_data_zero", 32'(bus.tx_data), 32'h0);

        // Reset mid-drain with a read in flight
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1, 4'b0001, 0, TX_A, 32'(8'h40 + i));
        check("queued_before_reset", 32'(bus.tx_valid), 32'h1);
        en                 = 1'b1;
        bus.mem_write_en   = 4'h0;
        bus.mem_read_en    = 1'b1;
        bus.mem_addr       = 32'h100;
        #2 rst = 1'b1;
        #1;
        check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h0);
        check("rst_read_data", bus.mem_read_data, 32'h0);
        @(posedge clk);
        #1;
        check("rst_cycle_read", bus.mem_read_data, 32'h0);
        rst = 1'b0;
        cyc(1, 4'h0, 1, STAT_A, 32'h0);
        check("status_after_reset", bus.mem_read_data, 32'h0);
        cyc(1, 4'h0, 1, 32'h100, 32'h0);
        check("ram_survives_reset", bus.mem_read_data, 32'hDEAD55EF);
        cyc(1, 4'h0, 1, 32'h1100, 32'h0);
        check("ram_alias", bus.mem_read_data, 32'hDEAD55EF);
        idle();

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
